// File: rtl/src_operand_sequencer_if.sv
// Purpose : bundles the issue, register-read and operand-result handshakes of the operand sequencer.
// Latency : n/a (wires only).
// Backpr. : issue_valid/issue_ready, rf_rd_en/rf_rd_ack and op_valid/op_ready carry the flow control.
// Modports: slave = sequencer view, master = requester / register-file / consumer view.
interface src_operand_sequencer_if;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  src_count;
    logic [11:0] src0_enc;
    logic [11:0] src1_enc;
    logic [11:0] src2_enc;
    logic [32:0] src0_fpconst;
    logic [32:0] src1_fpconst;
    logic [32:0] src2_fpconst;
    logic [31:0] literal;

    logic        rf_rd_en;
    logic [1:0]  rf_rd_sel;
    logic [9:0]  rf_rd_addr;
    logic        rf_rd_ack;
    logic [31:0] rf_rd_data;

    logic        op_valid;
    logic        op_ready;
    logic [31:0] op0_data;
    logic [31:0] op1_data;
    logic [31:0] op2_data;

    modport slave (
        input  issue_valid, src_count, src0_enc, src1_enc, src2_enc,
               src0_fpconst, src1_fpconst, src2_fpconst, literal,
               rf_rd_ack, rf_rd_data, op_ready,
        output issue_ready, rf_rd_en, rf_rd_sel, rf_rd_addr,
               op_valid, op0_data, op1_data, op2_data
    );

    modport master (
        output issue_valid, src_count, src0_enc, src1_enc, src2_enc,
               src0_fpconst, src1_fpconst, src2_fpconst, literal,
               rf_rd_ack, rf_rd_data, op_ready,
        input  issue_ready, rf_rd_en, rf_rd_sel, rf_rd_addr,
               op_valid, op0_data, op1_data, op2_data
    );
endinterface

// File: rtl/src_operand_sequencer.sv
// Purpose : fetches up to three source operands per instruction (immediates, float consts, literal, SGPR/VGPR/special reads).
// Latency : 1+src_count cycles when every source is a constant; each register read adds (ack wait + 1).
// Backpr. : one request in flight (issue_ready only in IDLE); results held until op_ready, reads held until rf_rd_ack.
// Ports   : clk, rst (synchronous, active-high); bus = src_operand_sequencer_if.slave.
// Option  : `define SRC_OPERAND_DEDUP_EN reuses captured data for a register encoding repeated within one request.
module src_operand_sequencer (
    input  logic                          clk,
    input  logic                          rst,
    src_operand_sequencer_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             rd_busy_q, rd_busy_d;
    logic [1:0]       rd_sel_q, rd_sel_d;
    logic [9:0]       rd_addr_q, rd_addr_d;

    // Request fields latched on acceptance; index 0 holds src0.
    logic [1:0]       cnt_q;
    logic [2:0][11:0] enc_q;
    logic [2:0][32:0] fp_q;
    logic [31:0]      lit_q;
    logic [2:0][31:0] op_q;

    logic             accept;
    logic             src_done;
    logic             cap_en;
    logic [31:0]      cap_dat;

    logic [11:0]      cur_enc;
    logic [32:0]      cur_fp;
    logic             cur_is_reg;
    logic [31:0]      const_val;
    logic [1:0]       reg_sel;
    logic [9:0]       reg_addr;
    logic             dup_hit;
    logic [31:0]      dup_val;

    assign accept = (state_q == IDLE) && bus.issue_valid;

    // Source currently being resolved.
    always_comb begin
        cur_enc = enc_q[0];
        cur_fp  = fp_q[0];
        case (idx_q)
            2'd1:    begin cur_enc = enc_q[1]; cur_fp = fp_q[1]; end
            2'd2:    begin cur_enc = enc_q[2]; cur_fp = fp_q[2]; end
            default: ;
        endcase
    end

    // Operand decode: bit11=0 is a constant; 10x is VGPR, 110 SGPR, 111 special.
    always_comb begin
        cur_is_reg = cur_enc[11];
        const_val  = {{22{cur_enc[9]}}, cur_enc[9:0]};
        if (cur_enc[10:0] == 11'h7FF) begin
            const_val = cur_fp[32] ? cur_fp[31:0] : lit_q;
        end
        reg_sel  = 2'b01;
        reg_addr = cur_enc[9:0];
        if (cur_enc[10]) begin
            reg_sel  = cur_enc[9] ? 2'b10 : 2'b00;
            reg_addr = {1'b0, cur_enc[8:0]};
        end
    end

`ifdef SRC_OPERAND_DEDUP_EN
    // An earlier source with the identical encoding is necessarily a register
    // already captured, so its data can stand in for a fresh read.
    always_comb begin
        dup_hit = 1'b0;
        dup_val = op_q[0];
        if ((idx_q != 2'd0) && (enc_q[0] == cur_enc)) begin
            dup_hit = 1'b1;
            dup_val = op_q[0];
        end else if ((idx_q == 2'd2) && (enc_q[1] == cur_enc)) begin
            dup_hit = 1'b1;
            dup_val = op_q[1];
        end
    end
`else
    assign dup_hit = 1'b0;
    assign dup_val = '0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_busy_d = rd_busy_q;
        rd_sel_d  = rd_sel_q;
        rd_addr_d = rd_addr_q;
        cap_en    = 1'b0;
        cap_dat   = const_val;
        src_done  = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d = 2'd0;
                if (accept) begin
                    state_d = (bus.src_count == 2'd0) ? OUT : FETCH;
                end
            end
            FETCH: begin
                if (rd_busy_q) begin
                    // rf_rd_ack only matters while a read is outstanding.
                    if (bus.rf_rd_ack) begin
                        cap_en    = 1'b1;
                        cap_dat   = bus.rf_rd_data;
                        rd_busy_d = 1'b0;
                        src_done  = 1'b1;
                    end
                end else if (!cur_is_reg) begin
                    cap_en   = 1'b1;
                    cap_dat  = const_val;
                    src_done = 1'b1;
                end else if (dup_hit) begin
                    cap_en   = 1'b1;
                    cap_dat  = dup_val;
                    src_done = 1'b1;
                end else begin
                    // Setup cycle: the request appears on the port next cycle,
                    // which gives the idle gap between back-to-back reads.
                    rd_busy_d = 1'b1;
                    rd_sel_d  = reg_sel;
                    rd_addr_d = reg_addr;
                end
                if (src_done) begin
                    if (idx_q == (cnt_q - 2'd1)) begin
                        state_d = OUT;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            OUT: begin
                if (bus.op_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            rd_busy_q <= 1'b0;
            rd_sel_q  <= 2'b00;
            rd_addr_q <= 10'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_busy_q <= rd_busy_d;
            rd_sel_q  <= rd_sel_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            enc_q <= '0;
            fp_q  <= '0;
            lit_q <= '0;
            op_q  <= '0;
        end else begin
            if (accept) begin
                cnt_q <= bus.src_count;
                enc_q <= {bus.src2_enc, bus.src1_enc, bus.src0_enc};
                fp_q  <= {bus.src2_fpconst, bus.src1_fpconst, bus.src0_fpconst};
                lit_q <= bus.literal;
                // Unfetched indices must read as zero.
                op_q  <= '0;
            end
            if (cap_en) begin
                case (idx_q)
                    2'd0:    op_q[0] <= cap_dat;
                    2'd1:    op_q[1] <= cap_dat;
                    default: op_q[2] <= cap_dat;
                endcase
            end
        end
    end

    assign bus.issue_ready = (state_q == IDLE);
    assign bus.op_valid    = (state_q == OUT);
    assign bus.rf_rd_en    = rd_busy_q;
    assign bus.rf_rd_sel   = rd_sel_q;
    assign bus.rf_rd_addr  = rd_addr_q;
    assign bus.op0_data    = op_q[0];
    assign bus.op1_data    = op_q[1];
    assign bus.op2_data    = op_q[2];

endmodule

// File: tb/tb_src_operand_sequencer.sv
module tb_src_operand_sequencer;

    logic clk;
    logic rst;

    src_operand_sequencer_if sif ();

    src_operand_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Register-file responder controls and logs.
    logic        resp_ack, man_ack;
    logic [31:0] resp_data, man_data;
    bit          auto_ack;
    int          fixed_delay;
    int          rd_cycles;
    logic [11:0] rd_log[$];

    // Observations of the most recent transaction.
    logic [31:0] last_op[3];
    int          last_lat;
    logic [11:0] last_rd[$];

    assign sif.rf_rd_ack  = resp_ack | man_ack;
    assign sif.rf_rd_data = man_ack ? man_data : resp_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register contents, keyed by {sel, addr}.
    function automatic logic [31:0] rf_val(input logic [11:0] key);
        return (32'(key) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [11:0] reg_key(input logic [11:0] e);
        case (e[11:9])
            3'b110:  return {2'b00, 1'b0, e[8:0]};
            3'b111:  return {2'b10, 1'b0, e[8:0]};
            default: return {2'b01, e[9:0]};
        endcase
    endfunction

    function automatic logic [31:0] model_src(input logic [11:0] e, input logic [32:0] fp, input logic [31:0] lit);
        int v;
        if (e[11]) return rf_val(reg_key(e));
        if (e[10:0] == 11'h7FF) return fp[32] ? fp[31:0] : lit;
        v = $signed(e[9:0]);
        return 32'(v);
    endfunction

    function automatic logic [11:0] rand_enc();
        logic [8:0] oh;
        oh = 9'b1 << $urandom_range(0, 8);
        case ($urandom_range(0, 5))
            0:       return {2'b00, 10'($urandom)};
            1:       return 12'h7FF;
            2:       return {2'b10, 10'($urandom)};
            3:       return {3'b110, 9'($urandom)};
            4:       return {3'b111, oh};
            default: return {1'b0, 11'($urandom)};
        endcase
    endfunction

    // Responder: acks each read after a chosen number of waiting cycles.
    initial begin : responder
        int          wcnt;
        int          cur_delay;
        bit          busy;
        logic [11:0] key0;
        resp_ack  = 1'b0;
        resp_data = '0;
        wcnt      = 0;
        cur_delay = 0;
        busy      = 1'b0;
        key0      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack) check("rd_en_drop_after_ack", 32'(sif.rf_rd_en), 32'd0);
            resp_ack = 1'b0;
            if (auto_ack && sif.rf_rd_en === 1'b1) begin
                if (!busy) begin
                    busy      = 1'b1;
                    wcnt      = 0;
                    cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                    key0      = {sif.rf_rd_sel, sif.rf_rd_addr};
                end else begin
                    check("rd_addr_stable", 32'({sif.rf_rd_sel, sif.rf_rd_addr}), 32'(key0));
                end
                if (wcnt == cur_delay) begin
                    resp_ack  = 1'b1;
                    resp_data = rf_val(key0);
                    rd_log.push_back(key0);
                    rd_cycles += cur_delay + 1;
                    busy      = 1'b0;
                end else begin
                    wcnt++;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    task automatic drive_req(input logic [1:0] cnt, input logic [11:0] e0, e1, e2,
                             input logic [32:0] f0, f1, f2, input logic [31:0] lit);
        sif.issue_valid  = 1'b1;
        sif.src_count    = cnt;
        sif.src0_enc     = e0;
        sif.src1_enc     = e1;
        sif.src2_enc     = e2;
        sif.src0_fpconst = f0;
        sif.src1_fpconst = f1;
        sif.src2_fpconst = f2;
        sif.literal      = lit;
    endtask

    task automatic scramble_req();
        sif.issue_valid  = 1'b0;
        sif.src_count    = 2'($urandom);
        sif.src0_enc     = 12'($urandom);
        sif.src1_enc     = 12'($urandom);
        sif.src2_enc     = 12'($urandom);
        sif.src0_fpconst = {1'($urandom), 32'($urandom)};
        sif.src1_fpconst = {1'($urandom), 32'($urandom)};
        sif.src2_fpconst = {1'($urandom), 32'($urandom)};
        sif.literal      = 32'($urandom);
    endtask

    task automatic run_req(input string tag, input logic [1:0] cnt, input logic [11:0] e0, e1, e2,
                           input logic [32:0] f0, f1, f2, input logic [31:0] lit, input int hold);
        logic [11:0] encs[3];
        logic [32:0] fps[3];
        logic [31:0] exp_op[3];
        logic [11:0] exp_rd[$];
        bit          dup;
        int          lat;
        encs = '{e0, e1, e2};
        fps  = '{f0, f1, f2};
        for (int i = 0; i < 3; i++) begin
            exp_op[i] = (i < int'(cnt)) ? model_src(encs[i], fps[i], lit) : 32'h0;
        end
        for (int i = 0; i < int'(cnt); i++) begin
            if (encs[i][11]) begin
                dup = 1'b0;
`ifdef SRC_OPERAND_DEDUP_EN
                for (int j = 0; j < i; j++) if (encs[j] == encs[i]) dup = 1'b1;
`endif
                if (!dup) exp_rd.push_back(reg_key(encs[i]));
            end
        end

        lat = 0;
        while (sif.issue_ready !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_issue_ready"}, 32'(sif.issue_ready), 32'd1);
        rd_log.delete();
        rd_cycles = 0;
        drive_req(cnt, e0, e1, e2, f0, f1, f2, lit);
        @(posedge clk); #1;
        scramble_req();

        lat = 1;
        while (sif.op_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        last_lat = lat;
        check({tag, "_latency"}, 32'(lat), 32'(1 + int'(cnt) + rd_cycles));
        check({tag, "_op0"}, sif.op0_data, exp_op[0]);
        check({tag, "_op1"}, sif.op1_data, exp_op[1]);
        check({tag, "_op2"}, sif.op2_data, exp_op[2]);
        check({tag, "_busy_not_ready"}, 32'(sif.issue_ready), 32'd0);
        check({tag, "_nreads"}, 32'(rd_log.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) begin
            check({tag, "_read_key"}, 32'(rd_log[i]), 32'(exp_rd[i]));
        end
        last_op[0] = sif.op0_data;
        last_op[1] = sif.op1_data;
        last_op[2] = sif.op2_data;
        last_rd    = rd_log;

        sif.op_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(sif.op_valid), 32'd1);
            check({tag, "_hold_op0"}, sif.op0_data, exp_op[0]);
            check({tag, "_hold_op1"}, sif.op1_data, exp_op[1]);
            check({tag, "_hold_op2"}, sif.op2_data, exp_op[2]);
        end
        sif.op_ready = 1'b1;
        @(posedge clk); #1;
        sif.op_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(sif.op_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(sif.issue_ready), 32'd1);
    endtask

    initial begin : main
        logic [11:0] e[3];
        int          n;
        rst         = 1'b1;
        man_ack     = 1'b0;
        man_data    = '0;
        auto_ack    = 1'b1;
        fixed_delay = -1;
        rd_cycles   = 0;
        drive_req(2'd0, '0, '0, '0, '0, '0, '0, '0);
        sif.issue_valid = 1'b0;
        sif.op_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_issue_ready", 32'(sif.issue_ready), 32'd1);
        check("rst_rd_en", 32'(sif.rf_rd_en), 32'd0);
        check("rst_op_valid", 32'(sif.op_valid), 32'd0);
        check("rst_op0", sif.op0_data, 32'h0);
        check("rst_op2", sif.op2_data, 32'h0);
        rst = 1'b0;

        // Two immediates: no reads, op_valid three cycles after acceptance.
        run_req("imm", 2'd2, 12'h040, 12'h3FF, 12'h000, '0, '0, '0, '0, 1);
        check("imm_lat3", 32'(last_lat), 32'd3);
        check("imm_op0", last_op[0], 32'h0000_0040);
        check("imm_op1", last_op[1], 32'hFFFF_FFFF);
        check("imm_op2_zero", last_op[2], 32'h0);
        check("imm_no_reads", 32'(last_rd.size()), 32'd0);

        // Float constant vs. literal selection.
        run_req("fpc", 2'd1, 12'h7FF, 12'hC01, 12'hC02, 33'h1_3F80_0000, '0, '0, 32'h1234_5678, 0);
        check("fpc_op0", last_op[0], 32'h3F80_0000);
        check("fpc_op1_zero", last_op[1], 32'h0);
        run_req("lit", 2'd1, 12'h7FF, 12'h000, 12'h000, 33'h0_3F80_0000, '0, '0, 32'hDEAD_BEEF, 0);
        check("lit_op0", last_op[0], 32'hDEAD_BEEF);

        // Zero sources: straight to OUT.
        run_req("cnt0", 2'd0, 12'hC05, 12'h040, 12'h040, '0, '0, '0, '0, 0);
        check("cnt0_lat1", 32'(last_lat), 32'd1);

        // SGPR, VGPR, special with two wait cycles each; 5-cycle op_ready stall.
        fixed_delay = 2;
        run_req("regs", 2'd3, 12'hC05, 12'h812, 12'hE04, '0, '0, '0, '0, 5);
        check("regs_lat", 32'(last_lat), 32'd13);
        check("regs_nrd", 32'(last_rd.size()), 32'd3);
        if (last_rd.size() == 3) begin
            check("regs_rd0", 32'(last_rd[0]), 32'h005);
            check("regs_rd1", 32'(last_rd[1]), 32'h412);
            check("regs_rd2", 32'(last_rd[2]), 32'h804);
        end
        check("regs_op1", last_op[1], rf_val(12'h412));

        // Repeated register encoding.
        fixed_delay = 1;
        run_req("dup", 2'd2, 12'hC07, 12'hC07, 12'h000, '0, '0, '0, '0, 0);
        check("dup_op0", last_op[0], rf_val(12'h007));
        check("dup_op1", last_op[1], rf_val(12'h007));
`ifdef SRC_OPERAND_DEDUP_EN
        check("dup_nrd", 32'(last_rd.size()), 32'd1);
`else
        check("dup_nrd", 32'(last_rd.size()), 32'd2);
`endif
        fixed_delay = -1;

        // Reset while a read is outstanding; a late ack must be ignored.
        auto_ack = 1'b0;
        drive_req(2'd1, 12'hC05, '0, '0, '0, '0, '0, '0);
        @(posedge clk); #1;
        scramble_req();
        n = 0;
        while (sif.rf_rd_en !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("abort_rd_en", 32'(sif.rf_rd_en), 32'd1);
        check("abort_rd_req", 32'({sif.rf_rd_sel, sif.rf_rd_addr}), 32'h005);
        repeat (2) @(posedge clk);
        #1;
        check("abort_rd_wait", 32'(sif.rf_rd_en), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        man_ack  = 1'b1;
        man_data = 32'hBAD0_BAD0;
        check("abort_en_low", 32'(sif.rf_rd_en), 32'd0);
        check("abort_idle", 32'(sif.issue_ready), 32'd1);
        @(posedge clk); #1;
        man_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort_no_valid", 32'(sif.op_valid), 32'd0);
            check("abort_op0", sif.op0_data, 32'h0);
            check("abort_en_stays_low", 32'(sif.rf_rd_en), 32'd0);
            @(posedge clk); #1;
        end
        auto_ack = 1'b1;

        // Reset wins over a simultaneous issue.
        rst = 1'b1;
        drive_req(2'd0, '0, '0, '0, '0, '0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        sif.issue_valid = 1'b0;
        check("rst_prio_ready", 32'(sif.issue_ready), 32'd1);
        check("rst_prio_valid", 32'(sif.op_valid), 32'd0);
        @(posedge clk); #1;
        check("rst_prio_valid2", 32'(sif.op_valid), 32'd0);

        // Reset while holding results in OUT clears them.
        drive_req(2'd1, 12'h005, '0, '0, '0, '0, '0, '0);
        @(posedge clk); #1;
        scramble_req();
        @(posedge clk); #1;
        check("outrst_valid", 32'(sif.op_valid), 32'd1);
        check("outrst_op0", sif.op0_data, 32'h5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("outrst_valid_low", 32'(sif.op_valid), 32'd0);
        check("outrst_op0_zero", sif.op0_data, 32'h0);
        check("outrst_ready", 32'(sif.issue_ready), 32'd1);

        // Recovery after aborts, then randomized requests.
        run_req("recover", 2'd1, 12'h812, '0, '0, '0, '0, '0, '0, 0);
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 3; i++) e[i] = rand_enc();
            if ($urandom_range(0, 2) == 0) e[1] = e[0];
            if ($urandom_range(0, 2) == 0) e[2] = e[$urandom_range(0, 1)];
            run_req("rand", 2'($urandom), e[0], e[1], e[2],
                    {1'($urandom), 32'($urandom)}, {1'($urandom), 32'($urandom)},
                    {1'($urandom), 32'($urandom)}, 32'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
